ysyx_23060187_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060187_mem_arbiter

Overview:
Shares the single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU), for the move from the single-cycle core to a multi-cycle core. Accepts one request at a time over a valid/ready handshake and issues it to the downstream memory port. Routes the memory response back to the requester that owns it. Sits between IFU/LSU and the memory wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MASK_W, 8, write-mask width (matches the memory wrapper mask)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  one-cycle pulse, ifu_rdata valid
ifu_rdata  out  DATA_W  fetched word
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_W  data address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  MASK_W  store byte mask
lsu_resp_valid  out  1  one-cycle pulse: load data or store ack
lsu_rdata  out  DATA_W  load data (0 for stores)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_wen  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_wmask  out  MASK_W  write mask
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_W  read data
grant_id  out  1  owner of current transaction, 0 = IFU, 1 = LSU
busy  out  1  state != IDLE

Behaviour:
- Reset: every output is 0. The state machine returns to IDLE. Latched request fields are cleared. A reset mid-transaction abandons the transaction, and any later stray mem_resp_valid is ignored.
- State machine: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If any req_valid is high, pick a winner and drive the winner's req_ready high combinationally in that cycle.
  - Latch addr, wen, wdata, wmask and grant_id. Force wen/wdata/wmask to 0 for IFU.
  - Go to ISSUE. The loser's req_ready stays 0, and the loser must hold its request.
- ISSUE:
  - mem_req_valid=1 with the latched fields. The fields must be stable until mem_req_ready.
  - On mem_req_ready go to WAIT.
- WAIT:
  - On mem_resp_valid, register mem_rdata (0 if wen) into the owner's rdata and pulse the owner's resp_valid for exactly one cycle on the next cycle.
  - Return to IDLE in the same transition.
- mem_resp_valid in IDLE or ISSUE is ignored.
- Minimum latency with a zero-wait memory: accept at cycle 0, mem_req_valid at cycle 1, mem_resp_valid at cycle 2, resp_valid at cycle 3.
- The IDLE cycle that raises resp_valid may also accept a new request.
- Only one transaction is outstanding at any time. req_ready is 0 outside IDLE.
- Default arbitration is fixed priority: LSU wins when both are valid.
- Idle outputs: mem_* and rdata outputs hold their last value while not valid.

Optional Feature:
- Macro: YSYX_23060187_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_grant register (reset value LSU) makes the requester not granted last win on a tie, so IFU wins the first tie after reset. A single requester always wins regardless of last_grant.
- Not defined: fixed LSU priority. There is no last_grant register.

Decomposition:
- Package ysyx_23060187_mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT)
  - constants ID_IFU=0 and ID_LSU=1
- One sub-module, ysyx_23060187_arb_pick, holds the winner selection logic:
  - combinational inputs: both valids and last_grant
  - output: winner id
  - the macro selects fixed or round-robin logic.

Test Plan:
- IFU read, addr 0x80000000, mem_req_ready=1, response 0x00100073 one cycle later -> ifu_resp_valid at cycle 3 with 0x00100073; lsu_resp_valid stays 0.
- IFU and LSU both valid at cycle 0 -> LSU granted first (grant_id=1), then IFU. With RR_EN after reset: IFU first, then LSU, and the next tie goes to IFU.
- LSU store, addr 0x80001000, wdata 0xdeadbeef, wmask 0x0f, mem_req_ready low for 5 cycles -> mem_* fields stable all 5 cycles; lsu_resp_valid pulses once with lsu_rdata=0.
- mem_resp_valid=1 with mem_rdata 0x12345678 while IDLE -> no resp_valid pulse and no state change.
- rst asserted in WAIT, then mem_resp_valid -> all outputs 0 next cycle, busy=0, no resp pulse.
- IFU requests held valid continuously with a zero-wait memory -> one ifu_resp_valid every 3 cycles, ifu_req_ready high only in IDLE.

Source files
------------

// File: rtl/ysyx_23060187_mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
//   arb_state_e : arbiter transaction state (IDLE, ISSUE, WAIT)
//   ID_IFU/ID_LSU : requester identifiers as carried on grant_id
package ysyx_23060187_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060187_arb_pick.sv
// Winner selection between the IFU and LSU request lines.
// Build option: define YSYX_23060187_ARB_RR_EN for round-robin on ties,
// otherwise the LSU always wins a tie.
// Ports:
//   ifu_valid, lsu_valid : pending requests
//   last_grant           : requester granted most recently (round-robin only)
//   winner               : selected requester id (ID_IFU / ID_LSU)
module ysyx_23060187_arb_pick
  import ysyx_23060187_mem_arb_pkg::*;
(
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic last_grant,
  output logic winner
);

`ifdef YSYX_23060187_ARB_RR_EN
  always_comb begin
    winner = ID_IFU;
    if (ifu_valid && lsu_valid) begin
      // Tie goes to whichever requester was not served last.
      winner = (last_grant == ID_LSU) ? ID_IFU : ID_LSU;
    end else if (lsu_valid) begin
      winner = ID_LSU;
    end
  end
`else
  always_comb begin
    winner = ID_IFU;
    if (lsu_valid) begin
      winner = ID_LSU;
    end
  end

  // Fixed priority only needs lsu_valid.
  logic [1:0] unused_fixed;
  assign unused_fixed = {ifu_valid, last_grant};
`endif

endmodule

// File: rtl/ysyx_23060187_mem_arbiter.sv
// Shares one memory port between the IFU and the LSU. One transaction is
// outstanding at a time: IDLE (accept) -> ISSUE (mem request) -> WAIT
// (mem response) -> IDLE, with the response registered back to its owner.
// Build option: YSYX_23060187_ARB_RR_EN selects round-robin arbitration.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ifu_req_* / ifu_resp_*   : IFU read request / response
//   lsu_req_* / lsu_resp_*   : LSU load/store request / response
//   mem_req_* / mem_resp_*   : downstream memory port
//   grant_id                 : owner of current transaction (0 IFU, 1 LSU)
//   busy                     : arbiter not idle
module ysyx_23060187_mem_arbiter
  import ysyx_23060187_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_id,
  output logic              busy
);

  arb_state_e state, state_next;
  logic       accept;
  logic       winner;
  logic       last_grant;
  logic       resp_fire;

`ifdef YSYX_23060187_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_LSU;
    end else if (accept) begin
      last_grant <= winner;
    end
  end
`else
  assign last_grant = ID_LSU;
`endif

  ysyx_23060187_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so no handshake completes while reset is held.
        if (!rst && (ifu_req_valid || lsu_req_valid)) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: if (mem_req_ready)  state_next = WAIT;
      WAIT:  if (mem_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ifu_req_ready = accept && (winner == ID_IFU);
  assign lsu_req_ready = accept && (winner == ID_LSU);
  assign mem_req_valid = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign resp_fire     = (state == WAIT) && mem_resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant_id       <= ID_IFU;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
    end else begin
      state          <= state_next;
      ifu_resp_valid <= resp_fire && (grant_id == ID_IFU);
      lsu_resp_valid <= resp_fire && (grant_id == ID_LSU);
      if (accept) begin
        grant_id <= winner;
        if (winner == ID_LSU) begin
          mem_wen   <= lsu_wen;
          mem_addr  <= lsu_addr;
          mem_wdata <= lsu_wdata;
          mem_wmask <= lsu_wmask;
        end else begin
          mem_wen   <= 1'b0;
          mem_addr  <= ifu_addr;
          mem_wdata <= '0;
          mem_wmask <= '0;
        end
      end
      if (resp_fire) begin
        if (grant_id == ID_IFU) begin
          ifu_rdata <= mem_rdata;
        end else begin
          lsu_rdata <= mem_wen ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
module tb_ysyx_23060187_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        grant_id, busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef YSYX_23060187_ARB_RR_EN
  localparam logic FIRST_TIE = 1'b0;
`else
  localparam logic FIRST_TIE = 1'b1;
`endif

  ysyx_23060187_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  // Drives a zero-wait memory from the ISSUE cycle; returns in the IDLE
  // cycle that carries the response pulse.
  task automatic mem_complete(input logic [31:0] rdata);
    mem_req_ready = 1;
    tick();
    mem_req_ready  = 0;
    mem_resp_valid = 1;
    mem_rdata      = rdata;
    tick();
    mem_resp_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    ifu_req_valid = 1;
    tick();
    tick();
    n_checks++;
    if (ifu_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", ifu_req_ready);
    end
    n_checks++;
    if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, grant_id, busy,
         ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs busy=%b addr=%h want all 0", busy, mem_addr);
    end
    ifu_req_valid = 0;
    rst = 0;
    tick();
  endtask

  task automatic test_ifu_read();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL ifu_accept: got %b want 10", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    ifu_req_valid = 0;
    n_checks++;
    if ({mem_req_valid, mem_wen, grant_id, busy} !== 4'b1001 || mem_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL ifu_issue: got v/wen/gid/busy=%b addr=%h want 1001 80000000",
                         {mem_req_valid, mem_wen, grant_id, busy}, mem_addr);
    end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0010_0073;
    n_checks++;
    if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_wait: got req_valid=%b resp=%b want 0 0", mem_req_valid, ifu_resp_valid);
    end
    tick();
    mem_resp_valid = 0;
    n_checks++;
    if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0010_0073 || lsu_resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ifu_resp: got v=%b d=%h lsu_v=%b busy=%b want 1 00100073 0 0",
                         ifu_resp_valid, ifu_rdata, lsu_resp_valid, busy);
    end
    tick();
    n_checks++;
    if (ifu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ifu_resp_pulse: got %b want 0", ifu_resp_valid);
    end
  endtask

  task automatic test_priority();
    logic w;
    clear_inputs();
    rst = 1; tick(); rst = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    #1;
    w = FIRST_TIE;
    n_checks++;
    if ({lsu_req_ready, ifu_req_ready} !== {w, ~w}) begin
      n_fail++; $display("FAIL tie1_ready: got lsu/ifu=%b want %b", {lsu_req_ready, ifu_req_ready}, {w, ~w});
    end
    tick();
    if (w) lsu_req_valid = 0; else ifu_req_valid = 0;
    n_checks++;
    if (grant_id !== w || mem_addr !== (w ? 32'h8000_2000 : 32'h8000_0010)) begin
      n_fail++; $display("FAIL tie1_grant: got gid=%b addr=%h want %b", grant_id, mem_addr, w);
    end
    mem_complete(32'h1111_2222);
    n_checks++;
    if ((w ? lsu_resp_valid : ifu_resp_valid) !== 1'b1 ||
        (w ? lsu_rdata : ifu_rdata) !== 32'h1111_2222) begin
      n_fail++; $display("FAIL tie1_resp: got ifu=%b lsu=%b want winner %b pulsed", ifu_resp_valid, lsu_resp_valid, w);
    end
    n_checks++;
    if ({lsu_req_ready, ifu_req_ready} !== {~w, w}) begin
      n_fail++; $display("FAIL second_ready: got lsu/ifu=%b want %b", {lsu_req_ready, ifu_req_ready}, {~w, w});
    end
    tick();
    if (w) ifu_req_valid = 0; else lsu_req_valid = 0;
    n_checks++;
    if (grant_id !== ~w) begin
      n_fail++; $display("FAIL second_grant: got %b want %b", grant_id, ~w);
    end
    mem_complete(32'h3333_4444);
    n_checks++;
    if ((w ? ifu_resp_valid : lsu_resp_valid) !== 1'b1 ||
        (w ? ifu_rdata : lsu_rdata) !== 32'h3333_4444) begin
      n_fail++; $display("FAIL second_resp: got ifu=%b lsu=%b want loser pulsed", ifu_resp_valid, lsu_resp_valid);
    end
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    n_checks++;
    if ({lsu_req_ready, ifu_req_ready} !== {FIRST_TIE, ~FIRST_TIE}) begin
      n_fail++; $display("FAIL tie2_ready: got lsu/ifu=%b want %b", {lsu_req_ready, ifu_req_ready}, {FIRST_TIE, ~FIRST_TIE});
    end
    tick();
    ifu_req_valid = 0; lsu_req_valid = 0;
    mem_complete(32'h0);
    tick();
  endtask

  task automatic test_store_stall();
    clear_inputs();
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hdead_beef; lsu_wmask = 8'h0f;
    tick();
    lsu_req_valid = 0; lsu_addr = 32'h0bad_0bad; lsu_wdata = 32'h5555_aaaa; lsu_wmask = 8'hff; lsu_wen = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({mem_req_valid, mem_wen, grant_id} !== 3'b111 || mem_addr !== 32'h8000_1000 ||
          mem_wdata !== 32'hdead_beef || mem_wmask !== 8'h0f) begin
        n_fail++; $display("FAIL store_stall_%0d: got v/wen/gid=%b addr=%h data=%h mask=%h want 111 80001000 deadbeef 0f",
                           i, {mem_req_valid, mem_wen, grant_id}, mem_addr, mem_wdata, mem_wmask);
      end
      tick();
    end
    mem_complete(32'hcafe_f00d);
    n_checks++;
    if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 32'h0 || ifu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL store_resp: got v=%b d=%h ifu_v=%b want 1 00000000 0", lsu_resp_valid, lsu_rdata, ifu_resp_valid);
    end
    tick();
    n_checks++;
    if (lsu_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL store_resp_pulse: got %b want 0", lsu_resp_valid);
    end
  endtask

  task automatic test_idle_resp();
    clear_inputs();
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000 || lsu_rdata !== 32'h0) begin
        n_fail++; $display("FAIL idle_resp_%0d: got ifu/lsu/busy=%b lsu_rdata=%h want 000 0",
                           i, {ifu_resp_valid, lsu_resp_valid, busy}, lsu_rdata);
      end
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    rst = 1;
    tick();
    rst = 0; mem_resp_valid = 1; mem_rdata = 32'h7777_8888;
    #1;
    n_checks++;
    if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, grant_id, busy,
         ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata, ifu_req_ready, lsu_req_ready} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got busy=%b addr=%h ifu_rdata=%h want all 0", busy, mem_addr, ifu_rdata);
    end
    tick();
    mem_resp_valid = 0;
    n_checks++;
    if ({ifu_resp_valid, lsu_resp_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_stray: got ifu/lsu/busy=%b want 000", {ifu_resp_valid, lsu_resp_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic fire_prev;
    clear_inputs();
    mem_req_ready = 1;
    fire_prev = 0;
    for (int c = 0; c <= 12; c++) begin
      ifu_req_valid  = (c < 12);
      ifu_addr       = 32'h8000_0100 + 32'(c);
      mem_resp_valid = fire_prev;
      mem_rdata      = 32'h0000_1000 + 32'(c);
      #1;
      n_checks++;
      if (ifu_req_ready !== (c % 3 == 0 && c < 12) || ifu_resp_valid !== (c % 3 == 0 && c > 0)) begin
        n_fail++; $display("FAIL b2b_cycle_%0d: got ready=%b resp=%b want %b %b", c, ifu_req_ready,
                           ifu_resp_valid, (c % 3 == 0 && c < 12), (c % 3 == 0 && c > 0));
      end
      if (c % 3 == 0 && c > 0) begin
        n_checks++;
        if (ifu_rdata !== 32'h0000_1000 + 32'(c - 1)) begin
          n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", c, ifu_rdata, 32'h0000_1000 + 32'(c - 1));
        end
      end
      fire_prev = mem_req_valid && mem_req_ready;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    test_reset();
    test_ifu_read();
    test_priority();
    test_store_stall();
    test_idle_resp();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
